// File: rtl/loop_sequencer_pkg.sv
// loop_sequencer_pkg: shared state encoding and default iteration-variable width
package loop_sequencer_pkg;
  localparam int ITERATION_VARIABLE_WIDTH = 16;
  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_RUN  = 2'd1,
    LS_DONE = 2'd2
  } ls_state_e;
endpackage

// File: rtl/loop_sequencer_if.sv
// loop_sequencer_if: config, handshake and iteration outputs of loop_sequencer
// iter_count exists only when LOOP_SEQ_ITER_COUNT_EN is defined
interface loop_sequencer_if #(parameter int W = loop_sequencer_pkg::ITERATION_VARIABLE_WIDTH);
  logic          start;
  logic signed [W-1:0] lb_i, ub_i, step_i, lb_j, ub_j, step_j;
  logic          ready;
  logic signed [W-1:0] i_var, j_var;
  logic          valid, last, done, busy;
`ifdef LOOP_SEQ_ITER_COUNT_EN
  logic [31:0]   iter_count;
`endif
  modport master (
    output start, lb_i, ub_i, step_i, lb_j, ub_j, step_j, ready,
    input  i_var, j_var, valid, last, done, busy
`ifdef LOOP_SEQ_ITER_COUNT_EN
    , input iter_count
`endif
  );
  modport slave (
    input  start, lb_i, ub_i, step_i, lb_j, ub_j, step_j, ready,
    output i_var, j_var, valid, last, done, busy
`ifdef LOOP_SEQ_ITER_COUNT_EN
    , output iter_count
`endif
  );
endinterface

// File: rtl/loop_sequencer_dim_counter.sv
// loop_dim_counter: one loop dimension holding latched lb/ub/step and the variable
module loop_dim_counter
  import loop_sequencer_pkg::*;
#(
  parameter int W = ITERATION_VARIABLE_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         advance,
  input  logic         rewind,
  input  logic [W-1:0] lb,
  input  logic [W-1:0] ub,
  input  logic [W-1:0] step,
  output logic [W-1:0] var_o,
  output logic         at_ub
);
  logic [W-1:0] lb_q, lb_d, ub_q, ub_d, step_q, step_d, var_q, var_d;
  always_comb begin
    lb_d   = load ? lb : lb_q;
    ub_d   = load ? ub : ub_q;
    step_d = load ? ((step == '0) ? W'(1) : step) : step_q;
    var_d  = load ? lb : rewind ? lb_q : advance ? var_q + step_q : var_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_q   <= '0;
      ub_q   <= '0;
      step_q <= '0;
      var_q  <= '0;
    end else begin
      lb_q   <= lb_d;
      ub_q   <= ub_d;
      step_q <= step_d;
      var_q  <= var_d;
    end
  end
  assign var_o = var_q;
  assign at_ub = var_q == ub_q;
endmodule

// File: rtl/loop_sequencer.sv
// loop_sequencer: row-major 2-D iteration sequencer with valid/ready handshake
// Define LOOP_SEQ_ITER_COUNT_EN to add the accepted-iteration counter
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int W = ITERATION_VARIABLE_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  loop_sequencer_if.slave bus
);
  ls_state_e    state_q, state_d;
  logic         load, accept, adv_i, rew_i, adv_j, at_ub_i, at_ub_j;
  logic [W-1:0] i_q, j_q;
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv_i   = 1'b0;
    rew_i   = 1'b0;
    adv_j   = 1'b0;
    accept  = (state_q == LS_RUN) && bus.ready;
    if (state_q == LS_IDLE && bus.start) begin
      load    = 1'b1;
      state_d = LS_RUN;
    end
    if (accept) begin
      adv_i   = !at_ub_i;
      rew_i   = at_ub_i && !at_ub_j;
      adv_j   = at_ub_i && !at_ub_j;
      state_d = (at_ub_i && at_ub_j) ? LS_DONE : LS_RUN;
    end
    if (state_q == LS_DONE) state_d = LS_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LS_IDLE;
    else        state_q <= state_d;
  end
  loop_dim_counter #(.W(W)) u_dim_i (
    .clk(clk), .rst_n(rst_n), .load(load), .advance(adv_i), .rewind(rew_i),
    .lb(bus.lb_i), .ub(bus.ub_i), .step(bus.step_i), .var_o(i_q), .at_ub(at_ub_i)
  );
  loop_dim_counter #(.W(W)) u_dim_j (
    .clk(clk), .rst_n(rst_n), .load(load), .advance(adv_j), .rewind(1'b0),
    .lb(bus.lb_j), .ub(bus.ub_j), .step(bus.step_j), .var_o(j_q), .at_ub(at_ub_j)
  );
  // Outputs decode registered state only, so ready/start never reach them combinationally
  assign bus.i_var = i_q;
  assign bus.j_var = j_q;
  assign bus.valid = state_q == LS_RUN;
  assign bus.last  = (state_q == LS_RUN) && at_ub_i && at_ub_j;
  assign bus.done  = state_q == LS_DONE;
  assign bus.busy  = state_q != LS_IDLE;
`ifdef LOOP_SEQ_ITER_COUNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? 32'd0 : accept ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.iter_count = cnt_q;
`endif
endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: directed and randomized runs checked against a nested-loop reference model
module tb_loop_sequencer;
  localparam int W = 16;
  typedef struct {
    logic signed [W-1:0] i;
    logic signed [W-1:0] j;
    logic                last;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total = 0;
  loop_sequencer_if #(.W(W)) ifc ();
  loop_sequencer #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int n_iter(input logic signed [W-1:0] lb, ub, st);
    logic signed [W-1:0] v, s;
    v = lb;
    s = (st == 0) ? 1 : st;
    for (int k = 1; k <= 1000; k++) begin
      if (v == ub) return k;
      v = v + s;
    end
    return 0;
  endfunction

  task automatic drive_cfg(input logic signed [W-1:0] lbi, ubi, sti, lbj, ubj, stj);
    ifc.lb_i = lbi; ifc.ub_i = ubi; ifc.step_i = sti;
    ifc.lb_j = lbj; ifc.ub_j = ubj; ifc.step_j = stj;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
  // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready
  task automatic run_seq(input logic signed [W-1:0] lbi, ubi, sti, lbj, ubj, stj,
                         input int mode, input bit inject);
    exp_t q[$];
    int   ni, nj, cyc, rc;
    logic rdy;
    logic signed [W-1:0] si, sj;
    ni = n_iter(lbi, ubi, sti);
    nj = n_iter(lbj, ubj, stj);
    si = (sti == 0) ? 1 : sti;
    sj = (stj == 0) ? 1 : stj;
    for (int b = 0; b < nj; b++)
      for (int a = 0; a < ni; a++)
        q.push_back('{lbi + W'(a) * si, lbj + W'(b) * sj, (a == ni - 1) && (b == nj - 1)});
    drive_cfg(lbi, ubi, sti, lbj, ubj, stj);
    ifc.start = 1'b1;
    ifc.ready = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;
    drive_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    cyc = 0;
    rc  = 0;
    while (q.size() > 0 && cyc < 400) begin
      chk("valid", 32'(ifc.valid), 1);
      chk("busy", 32'(ifc.busy), 1);
      chk("done_run", 32'(ifc.done), 0);
      chk("i_var", 32'(ifc.i_var), 32'(q[0].i));
      chk("j_var", 32'(ifc.j_var), 32'(q[0].j));
      chk("last", 32'(ifc.last), 32'(q[0].last));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (rc % 3 == 0) : 1'($urandom_range(0, 1));
      rc++;
      ifc.ready = rdy;
      ifc.start = inject && (cyc % 2 == 1);
      if (rdy) void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) begin
      chk("timeout", 32'(q.size()), 0);
      return;
    end
    chk("done_pulse", 32'(ifc.done), 1);
    chk("valid_done", 32'(ifc.valid), 0);
    chk("last_done", 32'(ifc.last), 0);
    chk("busy_done", 32'(ifc.busy), 1);
`ifdef LOOP_SEQ_ITER_COUNT_EN
    chk("iter_count", ifc.iter_count, 32'(ni * nj));
`endif
    ifc.ready = 1'($urandom_range(0, 1));
    ifc.start = inject;
    @(negedge clk);
    ifc.start = 1'b0;
    chk("done_clear", 32'(ifc.done), 0);
    chk("busy_idle", 32'(ifc.busy), 0);
    chk("valid_idle", 32'(ifc.valid), 0);
`ifdef LOOP_SEQ_ITER_COUNT_EN
    chk("iter_count_hold", ifc.iter_count, 32'(ni * nj));
`endif
  endtask

  initial begin
    int ni, nj;
    logic signed [W-1:0] lbi, sti, lbj, stj;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.ready = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifc.valid), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_done", 32'(ifc.done), 0);
    chk("rst_last", 32'(ifc.last), 0);
    chk("rst_i", 32'(ifc.i_var), 0);
    chk("rst_j", 32'(ifc.j_var), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(0, 2, 1, 0, 1, 1, 0, 1'b0);
    run_seq(5, -3, -4, 7, 7, 1, 0, 1'b0);
    run_seq(0, 2, 1, 0, 1, 1, 1, 1'b0);
    run_seq(0, 2, 1, 0, 1, 1, 0, 1'b1);
    run_seq(0, 2, 1, 0, 1, 1, 2, 1'b1);
    // abort mid-sequence after three accepts
    drive_cfg(0, 2, 1, 0, 1, 1);
    ifc.start = 1'b1;
    ifc.ready = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_i", 32'(ifc.i_var), 0);
    chk("pre_abort_j", 32'(ifc.j_var), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(ifc.valid), 0);
    chk("abort_busy", 32'(ifc.busy), 0);
    chk("abort_i", 32'(ifc.i_var), 0);
    chk("abort_j", 32'(ifc.j_var), 0);
`ifdef LOOP_SEQ_ITER_COUNT_EN
    chk("abort_count", ifc.iter_count, 0);
`endif
    @(negedge clk);
    chk("abort_no_done", 32'(ifc.done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", 32'(ifc.busy), 0);
    run_seq(0, 2, 1, 0, 1, 1, 0, 1'b0);
    run_seq(4, 4, 0, 0, 0, 0, 0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      ni  = $urandom_range(1, 4);
      nj  = $urandom_range(1, 3);
      lbi = W'($urandom);
      lbj = W'($urandom);
      sti = W'(int'($urandom_range(0, 100)) - 50);
      stj = W'(int'($urandom_range(0, 100)) - 50);
      run_seq(lbi, lbi + W'(ni - 1) * ((sti == 0) ? W'(1) : sti),
              sti, lbj, lbj + W'(nj - 1) * ((stj == 0) ? W'(1) : stj),
              stj, r % 3, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Two-dimensional iteration-variable sequencer for the Global Controller. Latches signed lower bound, upper bound and step for an inner (i) and outer (j) loop on `start`, then issues one (i, j) iteration per accepted cycle in row-major order under a valid/ready handshake. It flags the final iteration, pulses `done`, and returns to idle. Loop-exit detection uses equality compare against the upper bound, matching the Global Controller's existing iteration-variable comparison.

## Interface
- `ITERATION_VARIABLE_WIDTH`, 16, width of every iteration variable, bound and step (signed two's complement)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — reset, asynchronous and active-low
- `start` input 1 — begin sequence; sampled only in IDLE
- `lb_i`, `ub_i`, `step_i` input W each — inner loop config, signed
- `lb_j`, `ub_j`, `step_j` input W each — outer loop config, signed
- `ready` input 1 — consumer accepts current iteration
- `i_var`, `j_var` output W — current iteration variables
- `valid` output 1 — `i_var`/`j_var` hold a live iteration
- `last` output 1 — current iteration is the final one; qualified by `valid`
- `done` output 1 — one-cycle pulse after final iteration accepted
- `busy` output 1 — high in RUN and DONE
- `iter_count` output 32 — only with `LOOP_SEQ_ITER_COUNT_EN`; number of accepted iterations

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 → latch all six config inputs; load `i_var`=`lb_i`, `j_var`=`lb_j`; go RUN. Config inputs are ignored after latching.
- Step of 0 is latched as 1.
- RUN: `valid`=1. Accept = `valid & ready`. On accept:
  - i≠ub_i: i ← i+step_i, j unchanged.
  - i==ub_i and j≠ub_j: i ← lb_i, j ← j+step_j.
  - i==ub_i and j==ub_j: go DONE.
- `last` = (i==ub_i) & (j==ub_j) while in RUN.
- DONE: `done`=1 and `valid`=0 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored, with no queuing.
- Arithmetic is modulo 2^W. Exit uses equality only. If a bound is not reachable by lb + k·step, the loop wraps and never terminates. Software guarantees reachability; the block does not check.
- lb==ub in a dimension gives exactly one iteration of that dimension.
- Reset mid-operation aborts immediately with no `done` pulse.

## Timing
- Reset values: state=IDLE; `i_var`=`j_var`=0; `valid`=`last`=`done`=`busy`=0; `iter_count`=0.
- `start` at edge N → `valid`=1 with first iteration visible after edge N; `busy`=1 from the same point.
- One iteration per cycle maximum. Back-to-back accepts with `ready` held high.
- `ready`=0 holds `i_var`, `j_var`, `valid` and `last` stable.
- Final accept at edge M → `done`=1 during cycle M..M+1 → IDLE after edge M+1. Earliest restart is `start` sampled at edge M+2.
- Total cycles with `ready` held high: Ni·Nj iterations + 1 DONE cycle.
- All outputs are registered. There is no combinational path from `ready` or `start` to any output.

## Configuration
- `LOOP_SEQ_ITER_COUNT_EN` defined:
  - `iter_count` port is present.
  - It clears on accepted `start` and increments on every accept, wrapping at 2^32.
  - It holds its value after DONE until the next `start`.
- Not defined: the port and counter are absent. Sequencing behaviour is identical.

## Structure
- Shared package/header holds:
  - State encoding constants `LS_IDLE`=0, `LS_RUN`=1, `LS_DONE`=2, 2 bits.
  - Default `ITERATION_VARIABLE_WIDTH`.
- Sub-module `loop_dim_counter`, instantiated twice (i, j). It holds the latched lb/ub/step, the variable register, and an equality compare to ub. It provides load, advance and reset-to-lb controls and an `at_ub` output.
- Top level holds the FSM, handshake and optional counter.

## Test plan
- W=16; lb_i=0, ub_i=2, step_i=1; lb_j=0, ub_j=1, step_j=1; `ready`=1 → six iterations (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on consecutive cycles; `last` only on (2,1); `done` one cycle later; `iter_count`=6 if enabled.
- Signed/negative step: lb_i=5, ub_i=-3, step_i=-4; lb_j=ub_j=7 → i = 5, 1, -3 with j=7; `last` on -3.
- Backpressure: same config as the first case, `ready` toggling 1,0,0,1,… → values held during `ready`=0; still exactly six accepts; `done` one cycle after the sixth.
- `start` pulsed during RUN and during DONE → ignored; the sequence is unchanged; next `start` two cycles after the final accept is honoured.
- `rst_n` asserted mid-sequence (after 3 accepts) → all outputs 0 immediately with no `done`; a new `start` restarts from lb.
- step_i=0, lb_i=ub_i=4, lb_j=0, ub_j=0 → a single iteration (4,0) with `last`=1, then `done`.
